vectadd_dma_master: RTL and testbench

- Avalon-MM master for the vectadd on-chip RAM (14-bit word address, 32-bit data, byte enables, fixed read latency, no waitrequest).
- Driven by a start/length/base-address command.
- Reads element i of vector A and element i of vector B, writes A[i]+B[i] to vector C, for i = 0..len-1.
- Drives one RAM port (s1 or s2).

---
 rtl/vectadd_dma_master.sv | 224 ++++++++++++++++++++++
 tb/tb_vectadd_dma_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectadd_dma_master.sv
// ----------------------------------------------------------------------------
// vectadd_dma_master
//
// Avalon-MM master that computes C[i] = A[i] + B[i] for i = 0..len-1 against
// one port of the vectadd on-chip RAM. The RAM has a fixed read latency and
// no waitrequest, so every bus cycle completes in the cycle it is issued.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               command strobe (sampled only while idle)
//   src_a, src_b, dst   word base addresses of vectors A, B and C
//   len                 element count
//   busy                element processing in progress
//   done                one-cycle completion pulse
//   err                 one-cycle pulse: command rejected (out of range)
//   ovf                 sticky: some element sum carried out of DATA_W bits
//   address             RAM word address (holds its last value when idle)
//   chipselect, write   RAM access strobes
//   byteenable          constant all-ones
//   writedata           RAM write data (holds its last value when idle)
//   readdata            RAM read data, valid READ_LATENCY cycles after a read
//   dbg_state           current FSM state, for checkers and waveforms
//
// Command handshake: there is no ready signal. A command is taken on any
// clock edge where start=1 and the FSM is idle (dbg_state == IDLE, busy=0,
// done=0); start at any other edge is ignored. Every accepted command ends
// with exactly one done pulse, every rejected one with exactly one err pulse.
// ----------------------------------------------------------------------------
module vectadd_dma_master #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 12500,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_a,
    input  logic [ADDR_W-1:0]   src_b,
    input  logic [ADDR_W-1:0]   dst,
    input  logic [ADDR_W-1:0]   len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ovf,
    output logic [ADDR_W-1:0]   address,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        WAIT_A = 3'd2,
        RD_B   = 3'd3,
        WAIT_B = 3'd4,
        WR     = 3'd5,
        FIN    = 3'd6
    } state_t;

    // Range limit at ADDR_W+1 bits so base+len never wraps.
    localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [1:0]      LAT_LAST = 2'(READ_LATENCY - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_a_q, base_a_d;
    logic [ADDR_W-1:0]   base_b_q, base_b_d;
    logic [ADDR_W-1:0]   base_c_q, base_c_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          lat_q, lat_d;
    logic [DATA_W-1:0]   reg_a_q, reg_a_d;
    logic                carry_q, carry_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic [ADDR_W:0]     end_a, end_b, end_c;
    logic                cmd_bad;
    logic [ADDR_W-1:0]   idx_inc;
    logic [DATA_W:0]     elem_sum;

    assign end_a   = {1'b0, src_a} + {1'b0, len};
    assign end_b   = {1'b0, src_b} + {1'b0, len};
    assign end_c   = {1'b0, dst}   + {1'b0, len};
    assign cmd_bad = (end_a > MEM_LIM) || (end_b > MEM_LIM) || (end_c > MEM_LIM);
    assign idx_inc = idx_q + ADDR_W'(1);

    // B[i] is never stored on its own: the sum is formed the cycle B arrives
    // and registered straight into writedata, with its carry kept for WR.
    assign elem_sum = {1'b0, reg_a_q} + {1'b0, readdata};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
            reg_a_q  <= '0;
            carry_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_c_q <= base_c_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            reg_a_q  <= reg_a_d;
            carry_q  <= carry_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // The address register is loaded on entry to each bus state, so during
    // RD_A/RD_B/WR it already shows the right address and otherwise holds.
    always_comb begin
        state_d  = state_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_c_d = base_c_q;
        len_d    = len_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        reg_a_d  = reg_a_q;
        carry_d  = carry_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ovf_d    = ovf_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        state_d = FIN;
                    end else begin
                        base_a_d = src_a;
                        base_b_d = src_b;
                        base_c_d = dst;
                        len_d    = len;
                        idx_d    = '0;
                        ovf_d    = 1'b0;
                        addr_d   = src_a;
                        state_d  = RD_A;
                    end
                end
            end
            RD_A: begin
                lat_d   = '0;
                state_d = WAIT_A;
            end
            WAIT_A: begin
                if (lat_q == LAT_LAST) begin
                    reg_a_d = readdata;
                    addr_d  = base_b_q + idx_q;
                    state_d = RD_B;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            RD_B: begin
                lat_d   = '0;
                state_d = WAIT_B;
            end
            WAIT_B: begin
                if (lat_q == LAT_LAST) begin
                    wdata_d = elem_sum[DATA_W-1:0];
                    carry_d = elem_sum[DATA_W];
                    addr_d  = base_c_q + idx_q;
                    state_d = WR;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            WR: begin
                ovf_d = ovf_q | carry_q;
                idx_d = idx_inc;
                if (idx_inc < len_q) begin
                    addr_d  = base_a_q + idx_inc;
                    state_d = RD_A;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == RD_A) || (state_q == WAIT_A) || (state_q == RD_B) ||
                        (state_q == WAIT_B) || (state_q == WR);
    assign done       = (state_q == FIN);
    assign err        = err_q;
    assign ovf        = ovf_q;
    assign chipselect = (state_q == RD_A) || (state_q == RD_B) || (state_q == WR);
    assign write      = (state_q == WR);
    assign byteenable = '1;
    assign address    = addr_q;
    assign writedata  = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vectadd_dma_master.sv
// ----------------------------------------------------------------------------
// Bench for vectadd_dma_master. Two instances share one clock: dut 0 with
// READ_LATENCY=1 and dut 1 with READ_LATENCY=2, each with its own RAM model.
// A scoreboard predicts, from the vector-add rules, the bus trace every cycle
// (busy/done/err/chipselect/write/address/writedata/ovf) and a golden memory.
// ----------------------------------------------------------------------------
module tb_vectadd_dma_master;

    localparam int AW        = 14;
    localparam int DW        = 32;
    localparam int DEPTH     = 1 << AW;
    localparam int MEM_WORDS = 12500;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        cs;
        logic        wr;
        logic        chk_ovf;
        logic        ovf;
        logic [3:0]  be;
        logic [13:0] addr;
        logic [31:0] wdata;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n    [2];
    logic          start      [2];
    logic [AW-1:0] src_a      [2];
    logic [AW-1:0] src_b      [2];
    logic [AW-1:0] dst        [2];
    logic [AW-1:0] len        [2];
    logic          busy       [2];
    logic          done       [2];
    logic          err        [2];
    logic          ovf        [2];
    logic [AW-1:0] address    [2];
    logic          chipselect [2];
    logic          write      [2];
    logic [3:0]    byteenable [2];
    logic [DW-1:0] writedata  [2];
    logic [DW-1:0] readdata   [2];
    logic [2:0]    dbg_state  [2];

    vectadd_dma_master #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(1)) dut0 (
        .clk(clk), .reset_n(reset_n[0]), .start(start[0]),
        .src_a(src_a[0]), .src_b(src_b[0]), .dst(dst[0]), .len(len[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .ovf(ovf[0]),
        .address(address[0]), .chipselect(chipselect[0]), .write(write[0]),
        .byteenable(byteenable[0]), .writedata(writedata[0]), .readdata(readdata[0]),
        .dbg_state(dbg_state[0])
    );

    vectadd_dma_master #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(2)) dut1 (
        .clk(clk), .reset_n(reset_n[1]), .start(start[1]),
        .src_a(src_a[1]), .src_b(src_b[1]), .dst(dst[1]), .len(len[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .ovf(ovf[1]),
        .address(address[1]), .chipselect(chipselect[1]), .write(write[1]),
        .byteenable(byteenable[1]), .writedata(writedata[1]), .readdata(readdata[1]),
        .dbg_state(dbg_state[1])
    );

    // ---------------- RAM models (one per dut) ----------------
    logic [DW-1:0] ram     [2][DEPTH];
    logic [DW-1:0] rd_pipe [2][3];
    logic          ram_clr;
    logic          poke_en;
    int            poke_d;
    logic [AW-1:0] poke_a;
    logic [DW-1:0] poke_v;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rd_pipe[d][2] <= rd_pipe[d][1];
            rd_pipe[d][1] <= rd_pipe[d][0];
            rd_pipe[d][0] <= ram[d][address[d]];
            if (ram_clr) begin
                for (int a = 0; a < DEPTH; a++) ram[d][a] <= '0;
            end else if (poke_en && poke_d == d) begin
                ram[d][poke_a] <= poke_v;
            end else if (chipselect[d] && write[d]) begin
                ram[d][address[d]] <= writedata[d];
            end
        end
    end

    assign readdata[0] = rd_pipe[0][0];
    assign readdata[1] = rd_pipe[1][1];

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] model_mem [2][DEPTH];
    logic          ovf_exp   [2];
    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    int            total;
    int            bad;
    int            cyc;
    int            busy_cnt  [2];
    int            cs_cnt    [2];
    int            start_cyc [2];
    int            busy_base [2];
    int            cs_base   [2];
    logic          chk_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    function automatic exp_t idle_e(input int d);
        exp_t e;
        e         = '0;
        e.be      = 4'hF;
        e.chk_ovf = 1'b1;
        e.ovf     = ovf_exp[d];
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Predicts the bus trace of one command, starting with the cycle right
    // after the start edge, and applies its writes to the golden memory.
    task automatic expect_cmd(input int d, input int a, input int b, input int c, input int n);
        exp_t       e;
        int         lat;
        logic [32:0] sum;
        logic       carry_any;
        lat = (d == 0) ? 1 : 2;
        e = '0;
        e.be = 4'hF;
        if (a + n > MEM_WORDS || b + n > MEM_WORDS || c + n > MEM_WORDS) begin
            e.err = 1'b1;
            push(d, e);
        end else if (n == 0) begin
            e.done = 1'b1; e.chk_ovf = 1'b1; e.ovf = ovf_exp[d];
            push(d, e);
        end else begin
            carry_any = 1'b0;
            for (int i = 0; i < n; i++) begin
                sum = {1'b0, model_mem[d][a+i]} + {1'b0, model_mem[d][b+i]};
                model_mem[d][c+i] = sum[31:0];
                carry_any = carry_any | sum[32];
                e = '0; e.be = 4'hF; e.busy = 1'b1; e.cs = 1'b1; e.addr = AW'(a + i);
                push(d, e);
                e = '0; e.be = 4'hF; e.busy = 1'b1;
                for (int k = 0; k < lat; k++) push(d, e);
                e = '0; e.be = 4'hF; e.busy = 1'b1; e.cs = 1'b1; e.addr = AW'(b + i);
                push(d, e);
                e = '0; e.be = 4'hF; e.busy = 1'b1;
                for (int k = 0; k < lat; k++) push(d, e);
                e = '0; e.be = 4'hF; e.busy = 1'b1; e.cs = 1'b1; e.wr = 1'b1;
                e.addr = AW'(c + i); e.wdata = sum[31:0];
                push(d, e);
            end
            ovf_exp[d] = carry_any;
            e = '0; e.be = 4'hF; e.done = 1'b1; e.chk_ovf = 1'b1; e.ovf = carry_any;
            push(d, e);
        end
    endtask

    // Per-cycle compare of both duts against the predicted trace.
    task automatic monitor();
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (busy[d])       busy_cnt[d]++;
                if (chipselect[d]) cs_cnt[d]++;
                if (chk_on) begin
                    if (d == 0 && exp_q0.size() > 0)      e = exp_q0.pop_front();
                    else if (d == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                    else                                  e = idle_e(d);
                    act         = '0;
                    act.busy    = busy[d];
                    act.done    = done[d];
                    act.err     = err[d];
                    act.cs      = chipselect[d];
                    act.wr      = write[d];
                    act.be      = byteenable[d];
                    act.addr    = e.cs ? address[d] : '0;
                    act.wdata   = e.wr ? writedata[d] : '0;
                    act.chk_ovf = e.chk_ovf;
                    act.ovf     = e.chk_ovf ? ovf[d] : 1'b0;
                    total++;
                    if (act !== e) begin
                        bad++;
                        $display("FAIL bus_trace dut%0d cyc=%0d got=%h expected=%h", d, cyc, act, e);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic poke(input int d, input int a, input logic [31:0] v);
        poke_en = 1'b1; poke_d = d; poke_a = AW'(a); poke_v = v;
        model_mem[d][a] = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Returns one #1 after the start edge, i.e. early in cycle 1.
    task automatic issue(input int d, input int a, input int b, input int c, input int n);
        @(posedge clk); #1;
        src_a[d] = AW'(a); src_b[d] = AW'(b); dst[d] = AW'(c); len[d] = AW'(n);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d]     = 1'b0;
        start_cyc[d] = cyc;
        busy_base[d] = busy_cnt[d];
        cs_base[d]   = cs_cnt[d];
        expect_cmd(d, a, b, c, n);
    endtask

    // Latency in cycles from the start edge to the done cycle; -1 on timeout.
    task automatic wait_done(input int d, input int budget, output int latv);
        latv = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done[d] === 1'b1) begin
                latv = cyc - start_cyc[d];
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    int lt;
    logic [31:0] exp_c [4];
    logic [31:0] exp_ip [3];

    initial begin
        total = 0; bad = 0; cyc = 0; chk_on = 1'b0;
        ram_clr = 1'b1; poke_en = 1'b0; poke_d = 0; poke_a = '0; poke_v = '0;
        for (int d = 0; d < 2; d++) begin
            reset_n[d] = 1'b0; start[d] = 1'b0;
            src_a[d] = '0; src_b[d] = '0; dst[d] = '0; len[d] = '0;
            busy_cnt[d] = 0; cs_cnt[d] = 0; start_cyc[d] = 0;
            busy_base[d] = 0; cs_base[d] = 0; ovf_exp[d] = 1'b0;
            for (int a = 0; a < DEPTH; a++) model_mem[d][a] = '0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        chk_on = 1'b1;

        // Reset values
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'd0);
            chk($sformatf("rst_done%0d", d), 64'(done[d]), 64'd0);
            chk($sformatf("rst_err%0d", d), 64'(err[d]), 64'd0);
            chk($sformatf("rst_ovf%0d", d), 64'(ovf[d]), 64'd0);
            chk($sformatf("rst_cs%0d", d), 64'(chipselect[d]), 64'd0);
            chk($sformatf("rst_write%0d", d), 64'(write[d]), 64'd0);
            chk($sformatf("rst_addr%0d", d), 64'(address[d]), 64'd0);
            chk($sformatf("rst_wdata%0d", d), 64'(writedata[d]), 64'd0);
            chk($sformatf("rst_be%0d", d), 64'(byteenable[d]), 64'hF);
        end

        // Basic 4-element add, latency 1: 1 + 4*5 = 21 cycles
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) poke(0, i, 32'(i + 1));
        for (int i = 0; i < 4; i++) poke(0, 'h100 + i, 32'(10 * (i + 1)));
        issue(0, 'h000, 'h100, 'h200, 4);
        wait_done(0, 100, lt);
        chk("basic_latency", 64'(lt), 64'd21);
        chk("basic_busy_cycles", 64'(busy_cnt[0] - busy_base[0]), 64'd20);
        chk("basic_cs_cycles", 64'(cs_cnt[0] - cs_base[0]), 64'd12);
        chk("basic_ovf", 64'(ovf[0]), 64'd0);
        exp_c = '{32'd11, 32'd22, 32'd33, 32'd44};
        for (int i = 0; i < 4; i++) chk($sformatf("basic_c%0d", i), 64'(ram[0]['h200 + i]), 64'(exp_c[i]));

        // Same command with a second start during busy: must be ignored
        issue(0, 'h000, 'h100, 'h200, 4);
        repeat (4) @(posedge clk);
        #1;
        src_a[0] = AW'('h40); src_b[0] = AW'('h50); dst[0] = AW'('h300); len[0] = AW'(2);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, 100, lt);
        chk("busy_start_latency", 64'(lt), 64'd21);
        chk("busy_start_busy_cycles", 64'(busy_cnt[0] - busy_base[0]), 64'd20);
        chk("busy_start_c3", 64'(ram[0]['h203]), 64'd44);
        chk("busy_start_no_c300", 64'(ram[0]['h300]), 64'd0);

        // Carry out: 0xFFFFFFFF + 2 = 0x00000001 with ovf sticky
        poke(0, 'h20, 32'hFFFF_FFFF);
        poke(0, 'h30, 32'h0000_0002);
        issue(0, 'h20, 'h30, 'h240, 1);
        wait_done(0, 50, lt);
        chk("ovf_latency", 64'(lt), 64'd6);
        chk("ovf_sum", 64'(ram[0]['h240]), 64'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("ovf_sticky", 64'(ovf[0]), 64'd1);
        issue(0, 'h000, 'h100, 'h260, 1);
        @(negedge clk); #1;
        chk("ovf_cleared_on_start", 64'(ovf[0]), 64'd0);
        wait_done(0, 50, lt);
        chk("ovf_clear_latency", 64'(lt), 64'd6);
        chk("ovf_clear_sum", 64'(ram[0]['h260]), 64'd11);
        chk("ovf_clear_final", 64'(ovf[0]), 64'd0);

        // len = 0: done in the cycle after the start edge, no bus access
        issue(0, 'h000, 'h000, 'h200, 0);
        wait_done(0, 20, lt);
        chk("len0_latency", 64'(lt), 64'd1);
        chk("len0_cs_cycles", 64'(cs_cnt[0] - cs_base[0]), 64'd0);

        // Out of range: src_a=12499, len=2 -> 12501 > 12500
        issue(0, 12499, 'h000, 'h200, 2);
        @(negedge clk); #1;
        chk("rej_a_err", 64'(err[0]), 64'd1);
        chk("rej_a_busy", 64'(busy[0]), 64'd0);
        @(negedge clk); #1;
        chk("rej_a_err_one_cycle", 64'(err[0]), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rej_a_cs_cycles", 64'(cs_cnt[0] - cs_base[0]), 64'd0);
        chk("rej_a_busy_cycles", 64'(busy_cnt[0] - busy_base[0]), 64'd0);

        // Out of range through dst
        issue(0, 'h000, 'h000, 12499, 2);
        @(negedge clk); #1;
        chk("rej_c_err", 64'(err[0]), 64'd1);
        chk("rej_c_done", 64'(done[0]), 64'd0);

        // Exactly at the limit: 12496 + 4 = 12500 is accepted (in place)
        for (int i = 0; i < 4; i++) poke(0, 12496 + i, 32'(7 + i));
        issue(0, 12496, 12496, 12496, 4);
        wait_done(0, 100, lt);
        chk("limit_latency", 64'(lt), 64'd21);
        chk("limit_last", 64'(ram[0][12499]), 64'd20);

        // Reset during WAIT_B of element 2 (cycle 14 after the start edge)
        issue(0, 'h000, 'h100, 'h280, 4);
        repeat (13) @(posedge clk);
        #1;
        reset_n[0] = 1'b0;
        @(posedge clk); #1;
        reset_n[0] = 1'b1;
        exp_q0.delete();
        ovf_exp[0] = 1'b0;
        model_mem[0]['h282] = '0;
        model_mem[0]['h283] = '0;
        @(negedge clk); #1;
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_cs", 64'(chipselect[0]), 64'd0);
        chk("abort_addr", 64'(address[0]), 64'd0);
        chk("abort_wdata", 64'(writedata[0]), 64'd0);
        chk("abort_state_idle", 64'(dbg_state[0]), 64'd0);
        chk("abort_c1_written", 64'(ram[0]['h281]), 64'd22);
        chk("abort_c2_not_written", 64'(ram[0]['h282]), 64'd0);
        issue(0, 'h000, 'h100, 'h280, 4);
        wait_done(0, 100, lt);
        chk("after_abort_latency", 64'(lt), 64'd21);
        chk("after_abort_c2", 64'(ram[0]['h282]), 64'd33);
        chk("after_abort_c3", 64'(ram[0]['h283]), 64'd44);

        // In place, READ_LATENCY=2: 1 + 3*(3+2*2) = 22 cycles
        for (int i = 0; i < 3; i++) poke(1, 'h10 + i, 32'(5 + i));
        for (int i = 0; i < 3; i++) poke(1, 'h40 + i, 32'(100 * (i + 1)));
        issue(1, 'h10, 'h40, 'h10, 3);
        wait_done(1, 100, lt);
        chk("inplace_latency", 64'(lt), 64'd22);
        chk("inplace_busy_cycles", 64'(busy_cnt[1] - busy_base[1]), 64'd21);
        chk("inplace_cs_cycles", 64'(cs_cnt[1] - cs_base[1]), 64'd9);
        exp_ip = '{32'd105, 32'd206, 32'd307};
        for (int i = 0; i < 3; i++) chk($sformatf("inplace_a%0d", i), 64'(ram[1]['h10 + i]), 64'(exp_ip[i]));

        repeat (4) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
